// File: rtl/cash_pkg.sv
// Shared encodings for the cash dispenser: denominations, indices, widths and FSM states.
// The FAULT state only exists when CASH_ACK_TIMEOUT_EN is defined.
package cash_pkg;

    localparam int NOTE_W  = 8;
    localparam int IDX_W   = 3;
    localparam int NUM_DEN = 5;

    localparam logic [31:0] DEN_20000 = 32'd20000;
    localparam logic [31:0] DEN_10000 = 32'd10000;
    localparam logic [31:0] DEN_5000  = 32'd5000;
    localparam logic [31:0] DEN_2000  = 32'd2000;
    localparam logic [31:0] DEN_1000  = 32'd1000;

    localparam logic [IDX_W-1:0] IDX_20000 = 3'd0;
    localparam logic [IDX_W-1:0] IDX_10000 = 3'd1;
    localparam logic [IDX_W-1:0] IDX_5000  = 3'd2;
    localparam logic [IDX_W-1:0] IDX_2000  = 3'd3;
    localparam logic [IDX_W-1:0] IDX_1000  = 3'd4;
    // One past the last denomination: "search exhausted" / "nothing planned".
    localparam logic [IDX_W-1:0] IDX_NONE  = 3'd5;

`ifdef CASH_ACK_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, PLAN, GAP, REQ, DONE, REJECT, FAULT} state_t;
`else
    typedef enum logic [2:0] {IDLE, PLAN, GAP, REQ, DONE, REJECT} state_t;
`endif

    function automatic logic [31:0] den_value(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_20000: den_value = DEN_20000;
            IDX_10000: den_value = DEN_10000;
            IDX_5000:  den_value = DEN_5000;
            IDX_2000:  den_value = DEN_2000;
            IDX_1000:  den_value = DEN_1000;
            default:   den_value = 32'd0;
        endcase
    endfunction

    // Lowest index (largest denomination) with a non-zero count, IDX_NONE if all zero.
    function automatic logic [IDX_W-1:0] first_nonzero(
        input logic [NUM_DEN-1:0][NOTE_W-1:0] cnt
    );
        first_nonzero = IDX_NONE;
        for (int i = NUM_DEN - 1; i >= 0; i--) begin
            if (cnt[i] != '0) first_nonzero = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/cash_dispenser_ctrl_stock.sv
// Five per-denomination note counters with service-port load, single-note
// decrement and the low-stock flags. Load and decrement never coincide.
module note_stock
    import cash_pkg::*;
#(
    parameter int LOW_THRESH = 10
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             load_i,
    input  logic [IDX_W-1:0]                 load_idx_i,
    input  logic [NOTE_W-1:0]                load_cnt_i,
    input  logic                             dec_i,
    input  logic [IDX_W-1:0]                 dec_idx_i,
    output logic [NUM_DEN-1:0][NOTE_W-1:0]   stock_o,
    output logic [NUM_DEN-1:0]               stock_bajo_o
);

    localparam logic [NOTE_W:0] THRESH = (NOTE_W + 1)'(LOW_THRESH);

    logic [NUM_DEN-1:0][NOTE_W-1:0] stock_q, stock_d;

    always_comb begin
        stock_d = stock_q;
        if (load_i && (load_idx_i <= IDX_1000)) begin
            stock_d[load_idx_i] = load_cnt_i;
        end else if (dec_i && (dec_idx_i <= IDX_1000)) begin
            stock_d[dec_idx_i] = stock_q[dec_idx_i] - NOTE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) stock_q <= '0;
        else         stock_q <= stock_d;
    end

    always_comb begin
        stock_bajo_o = '0;
        for (int i = 0; i < NUM_DEN; i++) begin
            stock_bajo_o[i] = ({1'b0, stock_q[i]} < THRESH);
        end
    end

    assign stock_o = stock_q;

endmodule

// File: rtl/cash_dispenser_ctrl.sv
// Note dispenser sequencer: greedy plan against stock, then one req/ack per note.
// Define CASH_ACK_TIMEOUT_EN to add the ack watchdog and the sticky FAULT state.
module cash_dispenser_ctrl
    import cash_pkg::*;
#(
    parameter int MAX_NOTES   = 40,
    parameter int LOW_THRESH  = 10,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              entregar_dinero,
    input  logic [31:0]       monto,
    input  logic              carga_stb,
    input  logic [IDX_W-1:0]  carga_den,
    input  logic [NOTE_W-1:0] carga_cant,
    output logic              billete_req,
    output logic [IDX_W-1:0]  billete_den,
    input  logic              billete_ack,
    output logic              ocupado,
    output logic              entrega_ok,
    output logic              entrega_rechazada,
    output logic              falla,
    output logic [NUM_DEN-1:0] stock_bajo,
    output state_t            dbg_state
);

    localparam logic [15:0] MAX_N = 16'(MAX_NOTES);

    state_t                          state_q, state_d;
    logic [31:0]                     restante_q, restante_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [IDX_W-1:0]                den_q, den_d;
    logic [NUM_DEN-1:0][NOTE_W-1:0]  plan_q, plan_d;
    logic [15:0]                     total_q, total_d;

    logic                            load, dec;
    logic [IDX_W-1:0]                nxt;
    logic [31:0]                     cur_den;
    logic [NUM_DEN-1:0][NOTE_W-1:0]  stock;

`ifdef CASH_ACK_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
    logic [15:0] tmo_q, tmo_d;
`else
    logic unused_ack_timeout;
    assign unused_ack_timeout = ^ACK_TIMEOUT;
`endif

    note_stock #(
        .LOW_THRESH (LOW_THRESH)
    ) u_stock (
        .clk_i        (clk),
        .rst_ni       (rst),
        .load_i       (load),
        .load_idx_i   (carga_den),
        .load_cnt_i   (carga_cant),
        .dec_i        (dec),
        .dec_idx_i    (idx_q),
        .stock_o      (stock),
        .stock_bajo_o (stock_bajo)
    );

    always_comb begin
        state_d    = state_q;
        restante_d = restante_q;
        idx_d      = idx_q;
        den_d      = den_q;
        plan_d     = plan_q;
        total_d    = total_q;
        load       = 1'b0;
        dec        = 1'b0;
        nxt        = IDX_NONE;
        cur_den    = den_value(idx_q);
`ifdef CASH_ACK_TIMEOUT_EN
        tmo_d      = (state_q == REQ) ? tmo_q + 16'd1 : 16'd0;
`endif
        case (state_q)
            IDLE: begin
                // A load strobe always pre-empts a start request in the same cycle.
                if (carga_stb) begin
                    load = (carga_den <= IDX_1000);
                end else if (entregar_dinero) begin
                    if (monto == 32'd0) begin
                        state_d = REJECT;
                    end else begin
                        restante_d = monto;
                        idx_d      = IDX_20000;
                        plan_d     = '0;
                        total_d    = '0;
                        state_d    = PLAN;
                    end
                end
            end
            PLAN: begin
                if (restante_q == 32'd0) begin
                    idx_d   = first_nonzero(plan_q);
                    state_d = GAP;
                end else if ((idx_q == IDX_NONE) || (total_q == MAX_N)) begin
                    state_d = REJECT;
                end else if ((cur_den <= restante_q) && (plan_q[idx_q] < stock[idx_q])) begin
                    restante_d     = restante_q - cur_den;
                    plan_d[idx_q]  = plan_q[idx_q] + NOTE_W'(1);
                    total_d        = total_q + 16'd1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            GAP: begin
                den_d   = idx_q;
                state_d = REQ;
            end
            REQ: begin
                if (billete_ack) begin
                    dec           = 1'b1;
                    plan_d[idx_q] = plan_q[idx_q] - NOTE_W'(1);
                    nxt           = first_nonzero(plan_d);
                    idx_d         = nxt;
                    state_d       = (nxt == IDX_NONE) ? DONE : GAP;
                end
`ifdef CASH_ACK_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = FAULT;
                end
`endif
            end
            DONE:    state_d = IDLE;
            REJECT:  state_d = IDLE;
`ifdef CASH_ACK_TIMEOUT_EN
            FAULT:   state_d = FAULT;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            restante_q <= '0;
            idx_q      <= '0;
            den_q      <= '0;
            plan_q     <= '0;
            total_q    <= '0;
`ifdef CASH_ACK_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            restante_q <= restante_d;
            idx_q      <= idx_d;
            den_q      <= den_d;
            plan_q     <= plan_d;
            total_q    <= total_d;
`ifdef CASH_ACK_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // Mechanism handshake: billete_req stays high with billete_den stable until
    // the cycle billete_ack is sampled high; req then drops for at least one cycle.
    assign billete_req       = (state_q == REQ);
    assign billete_den       = den_q;
    assign ocupado           = (state_q != IDLE);
    assign entrega_ok        = (state_q == DONE);
    assign entrega_rechazada = (state_q == REJECT);
    assign dbg_state         = state_q;
`ifdef CASH_ACK_TIMEOUT_EN
    assign falla             = (state_q == FAULT);
`else
    assign falla             = 1'b0;
`endif

endmodule

// File: tb/tb_cash_dispenser_ctrl.sv
// Directed bench for cash_dispenser_ctrl: vector table plus hand sequences for
// reset-in-REQ, MAX_NOTES limit and the ack watchdog (CASH_ACK_TIMEOUT_EN).
module tb_cash_dispenser_ctrl;
    import cash_pkg::*;

    localparam int LOW_TH = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, entregar_dinero, carga_stb, ack, sel;
    logic [31:0] monto;
    logic [2:0]  carga_den;
    logic [7:0]  carga_cant;

    logic        a_req, a_ocu, a_ok, a_rej, a_falla, b_req, b_ocu, b_ok, b_rej, b_falla;
    logic [2:0]  a_den, b_den;
    logic [4:0]  a_bajo, b_bajo;
    state_t      a_state, b_state;
    logic        a_ack, b_ack;

    logic        billete_req, ocupado, entrega_ok, entrega_rechazada, falla;
    logic [2:0]  billete_den;
    logic [4:0]  stock_bajo;

    assign a_ack = ack & ~sel;
    assign b_ack = ack & sel;
    assign billete_req       = sel ? b_req   : a_req;
    assign billete_den       = sel ? b_den   : a_den;
    assign ocupado           = sel ? b_ocu   : a_ocu;
    assign entrega_ok        = sel ? b_ok    : a_ok;
    assign entrega_rechazada = sel ? b_rej   : a_rej;
    assign falla             = sel ? b_falla : a_falla;
    assign stock_bajo        = sel ? b_bajo  : a_bajo;

    cash_dispenser_ctrl #(.MAX_NOTES(40), .LOW_THRESH(LOW_TH), .ACK_TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .entregar_dinero(entregar_dinero), .monto(monto),
        .carga_stb(carga_stb), .carga_den(carga_den), .carga_cant(carga_cant),
        .billete_req(a_req), .billete_den(a_den), .billete_ack(a_ack),
        .ocupado(a_ocu), .entrega_ok(a_ok), .entrega_rechazada(a_rej),
        .falla(a_falla), .stock_bajo(a_bajo), .dbg_state(a_state)
    );

    cash_dispenser_ctrl #(.MAX_NOTES(4), .LOW_THRESH(LOW_TH), .ACK_TIMEOUT(255)) dut_b (
        .clk(clk), .rst(rst), .entregar_dinero(entregar_dinero), .monto(monto),
        .carga_stb(carga_stb), .carga_den(carga_den), .carga_cant(carga_cant),
        .billete_req(b_req), .billete_den(b_den), .billete_ack(b_ack),
        .ocupado(b_ocu), .entrega_ok(b_ok), .entrega_rechazada(b_rej),
        .falla(b_falla), .stock_bajo(b_bajo), .dbg_state(b_state)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];
    logic [7:0] stock_m [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_stock(input int i);
        return sel ? dut_b.u_stock.stock_q[i] : dut_a.u_stock.stock_q[i];
    endfunction

    task automatic check_stock(input string tag);
        logic [4:0] exp_bajo;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_stock%0d", tag, i), 32'(get_stock(i)), 32'(stock_m[i]));
            exp_bajo[i] = (stock_m[i] < 8'(LOW_TH));
        end
        check($sformatf("%s_stock_bajo", tag), 32'(stock_bajo), 32'(exp_bajo));
    endtask

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) stock_m[i] = 8'd0;
    endtask

    task automatic load(input logic [2:0] den, input logic [7:0] cnt, input bit taken);
        carga_stb = 1'b1; carga_den = den; carga_cant = cnt;
        @(negedge clk);
        carga_stb = 1'b0;
        if (taken && den <= 3'd4) stock_m[den] = cnt;
    endtask

    task automatic start_txn(input logic [31:0] m);
        entregar_dinero = 1'b1; monto = m;
        @(negedge clk);
        entregar_dinero = 1'b0;
    endtask

    task automatic serve(output bit ok_s, output bit rej_s, output bit to);
        int cyc;
        int d;
        ok_s = 1'b0; rej_s = 1'b0; to = 1'b1; cyc = 0;
        while (cyc < 500) begin
            if (entrega_ok) begin ok_s = 1'b1; to = 1'b0; break; end
            if (entrega_rechazada) begin rej_s = 1'b1; to = 1'b0; break; end
            if (billete_req) begin
                if (exp_q.size() == 0) check("unexpected_note", 32'(billete_req), 32'd0);
                else check("billete_den", 32'(billete_den), 32'(exp_q.pop_front()));
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                cyc += d;
                check("req_held", 32'(billete_req), 32'd1);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                cyc++;
                check("req_gap", 32'(billete_req), 32'd0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [31:0]     monto;
        logic [4:0][7:0] load;
        logic [4:0][7:0] plan;
        logic            ok;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] m,
                                input logic [7:0] s0, s1, s2, s3, s4,
                                input logic [7:0] p0, p1, p2, p3, p4,
                                input logic ok);
        vec_t v;
        v.monto = m;
        v.load[0] = s0; v.load[1] = s1; v.load[2] = s2; v.load[3] = s3; v.load[4] = s4;
        v.plan[0] = p0; v.plan[1] = p1; v.plan[2] = p2; v.plan[3] = p3; v.plan[4] = p4;
        v.ok = ok;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        bit ok_s, rej_s, to;
        for (int i = 0; i < 5; i++) load(3'(i), v.load[i], 1'b1);
        exp_q.delete();
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < int'(v.plan[i]); k++) exp_q.push_back(3'(i));
        start_txn(v.monto);
        serve(ok_s, rej_s, to);
        check({tag, "_timeout"}, 32'(to), 32'd0);
        check({tag, "_ok"}, 32'(ok_s), 32'(v.ok));
        check({tag, "_rej"}, 32'(rej_s), 32'(!v.ok));
        check({tag, "_notes_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_pulse_end"}, {29'd0, entrega_ok, entrega_rechazada, ocupado}, 32'd0);
        if (v.ok) for (int i = 0; i < 5; i++) stock_m[i] = stock_m[i] - v.plan[i];
        check_stock(tag);
    endtask

    vec_t vecs_a [9];
    vec_t vecs_b [2];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int lat;
        int n;
        rst = 1'b0; entregar_dinero = 1'b0; monto = '0; carga_stb = 1'b0;
        carga_den = '0; carga_cant = '0; ack = 1'b0; sel = 1'b0;

        vecs_a[0] = mk(32'd38000,  5,  5,  5,  5,  5,  1, 1, 1, 1, 1, 1'b1);
        vecs_a[1] = mk(32'd1500,  20, 20, 20, 20, 20,  0, 0, 0, 0, 0, 1'b0);
        vecs_a[2] = mk(32'd40000,  1,  0,  0,  0,  0,  0, 0, 0, 0, 0, 1'b0);
        vecs_a[3] = mk(32'd30000, 20, 20, 20, 20, 20,  1, 1, 0, 0, 0, 1'b1);
        vecs_a[4] = mk(32'd26000,  0,  2,  0,  3,  0,  0, 2, 0, 3, 0, 1'b1);
        vecs_a[5] = mk(32'd3000,   0,  0,  0,  5,  0,  0, 0, 0, 0, 0, 1'b0);
        vecs_a[6] = mk(32'd0,     20, 20, 20, 20, 20,  0, 0, 0, 0, 0, 1'b0);
        vecs_a[7] = mk(32'd57000, 12, 12, 12, 12, 12,  2, 1, 1, 1, 0, 1'b1);
        vecs_a[8] = mk(32'd1000,   9,  9,  9,  9,  9,  0, 0, 0, 0, 1, 1'b1);
        vecs_b[0] = mk(32'd5000,   0,  0,  0,  0, 10,  0, 0, 0, 0, 0, 1'b0);
        vecs_b[1] = mk(32'd4000,   0,  0,  0,  0, 10,  0, 0, 0, 0, 4, 1'b1);

        // Reset values
        do_reset();
        check("rst_state", 32'(a_state), 32'(IDLE));
        check("rst_outs", {26'd0, billete_req, ocupado, entrega_ok, entrega_rechazada, falla, 1'b0},
              32'd0);
        check("rst_den", 32'(billete_den), 32'd0);
        check_stock("rst");

        // Table-driven deliveries / rejects on the MAX_NOTES=40 instance
        for (int i = 0; i < 9; i++) run_vec(vecs_a[i], $sformatf("va%0d", i));

        // Out-of-range load index is ignored
        load(3'd5, 8'd77, 1'b0);
        check_stock("bad_den");

        // Load and start in the same cycle: load wins, start dropped
        carga_stb = 1'b1; carga_den = 3'd2; carga_cant = 8'd7;
        entregar_dinero = 1'b1; monto = 32'd5000;
        @(negedge clk);
        carga_stb = 1'b0; entregar_dinero = 1'b0;
        stock_m[2] = 8'd7;
        check("collide_ocupado", 32'(ocupado), 32'd0);
        repeat (8) @(negedge clk);
        check("collide_no_req", {30'd0, billete_req, entrega_rechazada}, 32'd0);
        check_stock("collide");

        // MAX_NOTES=4 instance
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 2; i++) run_vec(vecs_b[i], $sformatf("vb%0d", i));
        sel = 1'b0;

        // Reset during REQ after the first ack
        do_reset();
        for (int i = 0; i < 5; i++) load(3'(i), 8'd20, 1'b1);
        start_txn(32'd30000);
        lat = 0;
        while (!billete_req && lat < 50) begin @(negedge clk); lat++; end
        check("latency_30000", 32'(lat), 32'd5);
        check("first_den", 32'(billete_den), 32'd0);
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        stock_m[0] = stock_m[0] - 8'd1;
        n = 0;
        while (!billete_req && n < 20) begin @(negedge clk); n++; end
        check("second_req", 32'(billete_req), 32'd1);
        check("second_den", 32'(billete_den), 32'd1);
        load(3'd4, 8'd99, 1'b0);
        check("busy_still_req", 32'(billete_req), 32'd1);
        check_stock("busy_load");
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req", 32'(billete_req), 32'd0);
        check("rst_mid_ocupado", 32'(ocupado), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) stock_m[i] = 8'd0;
        check_stock("rst_mid");
        load(3'd2, 8'd15, 1'b1);
        check_stock("post_rst_load");

        // Ack watchdog
        do_reset();
        load(3'd0, 8'd3, 1'b1);
        start_txn(32'd20000);
        n = 0;
        while (!billete_req && n < 50) begin @(negedge clk); n++; end
        check("wd_req_rise", 32'(billete_req), 32'd1);
`ifdef CASH_ACK_TIMEOUT_EN
        n = 0;
        while (!falla && n < 100) begin @(negedge clk); n++; end
        check("wd_falla_delay", 32'(n), 32'd16);
        check("wd_fault_outs", {29'd0, billete_req, ocupado, falla}, 32'b011);
        start_txn(32'd20000);
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        repeat (4) @(negedge clk);
        check("wd_sticky", {27'd0, billete_req, ocupado, falla, entrega_ok, entrega_rechazada},
              32'b01100);
        check_stock("wd_fault");
        do_reset();
        check("wd_cleared", {30'd0, falla, ocupado}, 32'd0);
`else
        repeat (40) @(negedge clk);
        check("nowd_req_wait", 32'(billete_req), 32'd1);
        check("nowd_falla", 32'(falla), 32'd0);
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        n = 0;
        while (!entrega_ok && n < 20) begin @(negedge clk); n++; end
        check("nowd_ok", 32'(entrega_ok), 32'd1);
        stock_m[0] = 8'd2;
        @(negedge clk);
        check_stock("nowd");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
